vga_image_scanout: RTL
======================

# vga_image_scanout

Display back end of the MyISA processor system. It consumes the 8-bit grayscale image that the processor leaves in image RAM after it raises its end flag. It generates 640x480@60 Hz VGA timing from the 50 MHz board clock, fetches pixels from RAM through a synchronous read port, and drives `hsync`/`vsync`/`sync_b`/`blank_b`/`r`/`g`/`b` to the DAC. The image is shown centred on a black background and only when the processor reports it is complete.

## Interface
Parameters:
- `IMG_W`, 256: image width in pixels.
- `IMG_H`, 256: image height in pixels.
- `X0`, 192: first visible column of the image.
- `Y0`, 112: first visible row of the image.
- `ADDR_W`, 16: RAM address width; must satisfy `IMG_W*IMG_H <= 2**ADDR_W`.

Ports:
- `clk`, in, 1: 50 MHz system clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `img_ready`, in, 1: level; image RAM holds a complete frame (processor end flag).
- `rd_en`, out, 1: RAM read strobe.
- `rd_addr`, out, ADDR_W: RAM read address.
- `rd_data`, in, 8: RAM data, valid exactly one `clk` after `rd_en`.
- `hsync`, `vsync`, out, 1 each: active-low syncs.
- `sync_b`, out, 1: `hsync & vsync`.
- `blank_b`, out, 1: high in the 640x480 active area.
- `r`, `g`, `b`, out, 8 each: pixel colour.
- `frame_start`, out, 1: one-`clk` pulse at h=0, v=0.

## Operation
- Pixel tick `pix_en` toggles every `clk`, giving 25 MHz. It resets to 0; the first tick occurs on the second clock after reset release.
- Horizontal counter `h`, 0..799, advances on `pix_en`.
  - Active 0-639, front porch 640-655, sync 656-751, back porch 752-799.
  - Wraps to 0 and increments `v`.
- Vertical counter `v`, 0..524.
  - Active 0-479, front porch 480-489, sync 490-491, back porch 492-524.
  - Wraps to 0.
- Two-state FSM, WAIT and SHOW, evaluated only at the frame-start tick (h=0, v=0):
  - WAIT -> SHOW if `img_ready`=1.
  - SHOW -> WAIT if `img_ready`=0.
  - Changes to `img_ready` mid-frame are ignored until the next frame start.
- In-image region: `X0 <= h < X0+IMG_W` and `Y0 <= v < Y0+IMG_H`.
- On each `pix_en` in the in-image region while in SHOW:
  - `rd_en`=1 for that `clk`.
  - `rd_addr` = running pixel counter.
  - The counter clears at frame start, increments after each read, and never uses a multiplier.
  - The final read of a frame is `IMG_W*IMG_H-1`; no reads occur beyond it.
- Output colour:
  - Image region in SHOW: `r`=`g`=`b`=`rd_data`.
  - All other active-area pixels, and everything in WAIT: 0.
  - Blanking: `r`/`g`/`b`=0 and `blank_b`=0.

## Timing
- Reset values:
  - `hsync`=1, `vsync`=1, `sync_b`=1.
  - `blank_b`=0, `r`/`g`/`b`=0.
  - `rd_en`=0, `rd_addr`=0, `frame_start`=0.
  - `h`=`v`=0, FSM=WAIT.
- Reset mid-frame forces all of the above immediately (asynchronous). Scan restarts at h=0, v=0, and the FSM waits for the next frame-start evaluation.
- Pipeline: counters (stage 0) -> RAM address (stage 0, same `clk`) -> `rd_data` (+1 `clk`) -> registered outputs updated on the next `pix_en`.
  - Every output lags its counter position by exactly one pixel tick (2 `clk`).
  - Syncs and `blank_b` are delayed by the same amount, so colour and syncs stay aligned.
- Outputs change only on `clk` edges where `pix_en`=1, except `rd_en`/`frame_start`, which are single-`clk` pulses.
- Periods: line = 1600 `clk`, `hsync` low 192 `clk`; frame = 840000 `clk`, `vsync` low 3200 `clk`.

## Configuration
- `VGA_BORDER_EN` defined:
  - In SHOW, the 1-pixel ring just outside the image (columns `X0-1` and `X0+IMG_W`, rows `Y0-1` and `Y0+IMG_H`, spanning the full ring) outputs `r`=0xFF, `g`=0, `b`=0.
  - No RAM read occurs for ring pixels.
  - Requires `X0>=1` and `Y0>=1`.
- `VGA_BORDER_EN` undefined: ring pixels are black; no extra logic.

## Test plan
- Reset held low 5 cycles, then released -> all outputs at their reset values during reset; first `frame_start` pulse within 4 `clk` of release.
- Free-run 2 frames with `img_ready`=0:
  - `hsync` period 1600 `clk`, low 192 `clk`.
  - `vsync` low 3200 `clk` every 840000 `clk`.
  - `rd_en` never asserted; `r`/`g`/`b`=0 throughout.
- `img_ready`=1 before frame start; RAM model returns `addr[7:0]` with 1-cycle latency:
  - Output pixel (192,112)=0x00, (193,112)=0x01, (192,113)=0x00, (447,367)=0xFF.
  - Last `rd_addr`=65535; 65536 `rd_en` pulses per frame.
- `img_ready` raised mid-frame -> remainder of that frame black with no reads; the next frame shows the image.
- With `VGA_BORDER_EN`, `img_ready`=1 -> pixel (191,200) and (300,111) = FF/00/00; (192,112) still 0x00; without the macro, both border pixels = 0.
- Reset asserted at h=300, v=200 in SHOW -> outputs return to reset values within the same `clk`; after release, syncs restart from line 0 and the image reappears on the next frame start.

Source files
------------

// File: rtl/vga_image_scanout.sv
// 640x480@60 VGA scan-out of an 8-bit grayscale frame read from a synchronous image RAM.
// Define VGA_BORDER_EN to draw a red 1-pixel ring around the image while it is shown.
module vga_image_scanout #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int X0     = 192,
  parameter int Y0     = 112,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              img_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              hsync,
  output logic              vsync,
  output logic              sync_b,
  output logic              blank_b,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              frame_start
);

  localparam logic [9:0] H_ACT    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd751;
  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_ACT    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd491;
  localparam logic [9:0] V_LAST   = 10'd524;

  typedef enum logic {ST_WAIT, ST_SHOW} state_e;

  state_e            state_q, state_d;
  logic              pix_en_q, pix_en_d;
  logic [9:0]        h_q, h_d, v_q, v_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic              blank_q, blank_d, fs_q, fs_d;
  logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
  logic              frame_tick, show, active, in_img, in_ring, hs_now, vs_now;
  int                h_i, v_i;

  assign h_i        = int'(h_q);
  assign v_i        = int'(v_q);
  assign frame_tick = pix_en_q && (h_q == '0) && (v_q == '0);

  always_comb begin
    pix_en_d = ~pix_en_q;
    h_d      = h_q;
    v_d      = v_q;
    if (pix_en_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Display state only changes on the frame-start tick, so a frame is never half shown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_WAIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_tick) state_d = img_ready ? ST_SHOW : ST_WAIT;
  end

  always_comb show = (state_q == ST_SHOW);

  always_comb begin
    in_img = (h_i >= X0) && (h_i < X0 + IMG_W) && (v_i >= Y0) && (v_i < Y0 + IMG_H);
`ifdef VGA_BORDER_EN
    in_ring = !in_img && (h_i >= X0 - 1) && (h_i <= X0 + IMG_W)
                      && (v_i >= Y0 - 1) && (v_i <= Y0 + IMG_H);
`else
    in_ring = 1'b0;
`endif
    active = (h_q < H_ACT) && (v_q < V_ACT);
    hs_now = !((h_q >= H_SYNC_S) && (h_q <= H_SYNC_E));
    vs_now = !((v_q >= V_SYNC_S) && (v_q <= V_SYNC_E));
  end

  // The read goes out in the first clk of the pixel so its data lands before the output tick.
  assign rd_en   = show && in_img && !pix_en_q;
  assign rd_addr = cnt_q;

  always_comb begin
    // NOTE: every _d gets a default first, so state holds between ticks and no latch is inferred.
    cnt_d   = cnt_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    blank_d = blank_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    fs_d    = frame_tick;
    if (frame_tick)  cnt_d = '0;
    else if (rd_en)  cnt_d = cnt_q + ADDR_W'(1);
    if (pix_en_q) begin
      hsync_d = hs_now;
      vsync_d = vs_now;
      blank_d = active;
      r_d     = '0;
      g_d     = '0;
      b_d     = '0;
      if (active && show) begin
        if (in_img) begin
          r_d = rd_data;
          g_d = rd_data;
          b_d = rd_data;
        end else if (in_ring) begin
          r_d = 8'hFF;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_en_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      cnt_q    <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      blank_q  <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      fs_q     <= 1'b0;
    end else begin
      pix_en_q <= pix_en_d;
      h_q      <= h_d;
      v_q      <= v_d;
      cnt_q    <= cnt_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      blank_q  <= blank_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      fs_q     <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign sync_b      = hsync_q & vsync_q;
  assign blank_b     = blank_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign frame_start = fs_q;

endmodule
